// File: rtl/lockstep_pkg.sv
// Shared types for the lockstep trace checker.
// trace_entry_t is one captured store with the default address and data widths.
// chk_state_t is the compare FSM state.
package lockstep_pkg;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DATA_W = 32;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } trace_entry_t;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    WAIT = 2'd1,
    HALT = 2'd2
  } chk_state_t;

endpackage

// File: rtl/trace_fifo.sv
// Register-based FIFO holding one core's store trace.
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   clr_i           synchronous clear (empties the FIFO)
//   push_i, data_i  write request and entry
//   pop_i           remove the head (ignored when empty)
//   head_o          current head entry
//   empty_o         no entries held
//   drop_o          push refused this cycle (full with no pop)
module trace_fifo
  import lockstep_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = $bits(trace_entry_t)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             empty_o,
  output logic             drop_o
);

  localparam int unsigned PW   = $clog2(DEPTH);
  localparam int unsigned PTRW = PW + 1;

  logic [PTRW-1:0]  wr_q, wr_d, rd_q, rd_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             full;
  logic             pop_ok;
  logic             push_ok;

  // Extra wrap bit distinguishes full from empty when the indices coincide.
  assign empty_o = (wr_q == rd_q);
  assign full    = (wr_q[PW] != rd_q[PW]) && (wr_q[PW-1:0] == rd_q[PW-1:0]);
  assign pop_ok  = pop_i && !empty_o;
  // A full FIFO still accepts a push when its head leaves in the same cycle.
  assign push_ok = push_i && (!full || pop_ok);
  assign drop_o  = push_i && !push_ok;
  assign head_o  = mem_q[rd_q[PW-1:0]];

  // Pointer next state.
  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (clr_i) begin
      wr_d = '0;
      rd_d = '0;
    end else begin
      if (push_ok) wr_d = wr_q + PTRW'(1);
      if (pop_ok)  rd_d = rd_q + PTRW'(1);
    end
  end

  // Pointer registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Entry storage; contents are meaningless until the pointers cover them.
  always_ff @(posedge clk_i) begin
    if (push_ok && !clr_i) mem_q[wr_q[PW-1:0]] <= data_i;
  end

endmodule

// File: rtl/lockstep_trace_checker.sv
// Compares the data-memory store traces of a reference core and a DUT core
// in program order, independent of their relative cycle offset.
// Ports:
//   CLK, RESET_N                  clock, asynchronous active-low reset
//   CLEAR                         synchronous clear, same effect as reset
//   ref_valid/ref_addr/ref_data   reference core store
//   dut_valid/dut_addr/dut_data   DUT core store
//   match_count, mismatch_count   saturating pair counters
//   mismatch                      sticky, any pair differed
//   first_ref_*/first_dut_*       pair of the first mismatch
//   overflow                      sticky, an entry was dropped on a full FIFO
//   timeout                       sticky, one trace led for TIMEOUT cycles
//   halted                        comparison stopped after a mismatch
module lockstep_trace_checker
  import lockstep_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH       = 10,
  parameter int unsigned DATA_WIDTH       = 32,
  parameter int unsigned DEPTH            = 8,
  parameter int unsigned CNT_WIDTH        = 16,
  parameter int unsigned TIMEOUT          = 64,
  parameter bit          STOP_ON_MISMATCH = 1'b1
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic                  CLEAR,
  input  logic                  ref_valid,
  input  logic [ADDR_WIDTH-1:0] ref_addr,
  input  logic [DATA_WIDTH-1:0] ref_data,
  input  logic                  dut_valid,
  input  logic [ADDR_WIDTH-1:0] dut_addr,
  input  logic [DATA_WIDTH-1:0] dut_data,
  output logic [CNT_WIDTH-1:0]  match_count,
  output logic [CNT_WIDTH-1:0]  mismatch_count,
  output logic                  mismatch,
  output logic [ADDR_WIDTH-1:0] first_ref_addr,
  output logic [DATA_WIDTH-1:0] first_ref_data,
  output logic [ADDR_WIDTH-1:0] first_dut_addr,
  output logic [DATA_WIDTH-1:0] first_dut_data,
  output logic                  overflow,
  output logic                  timeout,
  output logic                  halted
);

  localparam int unsigned EW  = ADDR_WIDTH + DATA_WIDTH;
  localparam int unsigned WCW = $clog2(TIMEOUT + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  chk_state_t state_q, state_d;
  logic [WCW-1:0]        wait_q, wait_d;
  logic [CNT_WIDTH-1:0]  mcnt_q, mcnt_d, mmcnt_q, mmcnt_d;
  logic                  mis_q, mis_d, ovf_q, ovf_d, to_q, to_d, halted_q, halted_d;
  logic [ADDR_WIDTH-1:0] fra_q, fra_d, fda_q, fda_d;
  logic [DATA_WIDTH-1:0] frd_q, frd_d, fdd_q, fdd_d;

  logic [EW-1:0] ref_head, dut_head;
  logic          ref_empty, dut_empty, ref_drop, dut_drop;
  logic          do_pop, is_match, halt_now, one_pending;

  trace_fifo #(.DEPTH(DEPTH), .WIDTH(EW)) u_ref_fifo (
    .clk_i   (CLK),
    .rst_ni  (RESET_N),
    .clr_i   (CLEAR),
    .push_i  (ref_valid),
    .data_i  ({ref_addr, ref_data}),
    .pop_i   (do_pop),
    .head_o  (ref_head),
    .empty_o (ref_empty),
    .drop_o  (ref_drop)
  );

  trace_fifo #(.DEPTH(DEPTH), .WIDTH(EW)) u_dut_fifo (
    .clk_i   (CLK),
    .rst_ni  (RESET_N),
    .clr_i   (CLEAR),
    .push_i  (dut_valid),
    .data_i  ({dut_addr, dut_data}),
    .pop_i   (do_pop),
    .head_o  (dut_head),
    .empty_o (dut_empty),
    .drop_o  (dut_drop)
  );

  // Heads pop together only when both traces have an entry.
  assign do_pop      = !ref_empty && !dut_empty && (state_q != HALT);
  assign is_match    = (ref_head == dut_head);
  assign halt_now    = do_pop && !is_match && STOP_ON_MISMATCH;
  assign one_pending = (ref_empty != dut_empty);

  // Compare bookkeeping and FSM next state.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    mcnt_d  = mcnt_q;
    mmcnt_d = mmcnt_q;
    mis_d   = mis_q;
    ovf_d   = ovf_q;
    to_d    = to_q;
    fra_d   = fra_q;
    frd_d   = frd_q;
    fda_d   = fda_q;
    fdd_d   = fdd_q;
    if (CLEAR) begin
      state_d = RUN;
      wait_d  = '0;
      mcnt_d  = '0;
      mmcnt_d = '0;
      mis_d   = 1'b0;
      ovf_d   = 1'b0;
      to_d    = 1'b0;
      fra_d   = '0;
      frd_d   = '0;
      fda_d   = '0;
      fdd_d   = '0;
    end else begin
      if (do_pop) begin
        if (is_match) begin
          if (mcnt_q != CNT_MAX) mcnt_d = mcnt_q + CNT_WIDTH'(1);
        end else begin
          if (mmcnt_q != CNT_MAX) mmcnt_d = mmcnt_q + CNT_WIDTH'(1);
          mis_d = 1'b1;
          // Only the very first differing pair is kept.
          if (!mis_q) begin
            fra_d = ref_head[EW-1:DATA_WIDTH];
            frd_d = ref_head[DATA_WIDTH-1:0];
            fda_d = dut_head[EW-1:DATA_WIDTH];
            fdd_d = dut_head[DATA_WIDTH-1:0];
          end
        end
      end
      if (ref_drop || dut_drop) ovf_d = 1'b1;
      case (state_q)
        RUN: begin
          if (halt_now) begin
            state_d = HALT;
          end else if (one_pending) begin
            state_d = WAIT;
            wait_d  = WCW'(1);
          end
        end
        WAIT: begin
          if (halt_now) begin
            state_d = HALT;
          end else if (do_pop || (ref_empty && dut_empty)) begin
            state_d = RUN;
            wait_d  = '0;
          end else if (wait_q == WCW'(TIMEOUT)) begin
            // Counter parks at the limit; the flag is sticky.
            to_d = 1'b1;
          end else begin
            wait_d = wait_q + WCW'(1);
          end
        end
        HALT: ;
        default: state_d = RUN;
      endcase
    end
    halted_d = (state_d == HALT);
  end

  // State and output registers.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= RUN;
      wait_q   <= '0;
      mcnt_q   <= '0;
      mmcnt_q  <= '0;
      mis_q    <= 1'b0;
      ovf_q    <= 1'b0;
      to_q     <= 1'b0;
      halted_q <= 1'b0;
      fra_q    <= '0;
      frd_q    <= '0;
      fda_q    <= '0;
      fdd_q    <= '0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      mcnt_q   <= mcnt_d;
      mmcnt_q  <= mmcnt_d;
      mis_q    <= mis_d;
      ovf_q    <= ovf_d;
      to_q     <= to_d;
      halted_q <= halted_d;
      fra_q    <= fra_d;
      frd_q    <= frd_d;
      fda_q    <= fda_d;
      fdd_q    <= fdd_d;
    end
  end

  assign match_count    = mcnt_q;
  assign mismatch_count = mmcnt_q;
  assign mismatch       = mis_q;
  assign first_ref_addr = fra_q;
  assign first_ref_data = frd_q;
  assign first_dut_addr = fda_q;
  assign first_dut_data = fdd_q;
  assign overflow       = ovf_q;
  assign timeout        = to_q;
  assign halted         = halted_q;

endmodule

// File: doc/lockstep_trace_checker.md
# lockstep_trace_checker

Synthesizable lockstep checker for RISC-V core verification. It captures the data-memory write trace of a reference core (single-cycle golden) and a DUT core (pipelined), one entry per store. Each trace is buffered in its own FIFO, so cycle offsets between the cores do not matter. Entries are compared in program order, with match/mismatch counts, first-mismatch capture, overflow and timeout flags. It sits beside the two cores in the co-simulation top and replaces ad-hoc waveform comparison.

## Interface
- ADDR_WIDTH, 10, data-memory address width
- DATA_WIDTH, 32, store data width
- DEPTH, 8, entries per trace FIFO; power of two, ≥2
- CNT_WIDTH, 16, width of match/mismatch counters
- TIMEOUT, 64, max cycles one trace may lead the other; ≥1
- STOP_ON_MISMATCH, 1, 1: halt comparison after first mismatch; 0: keep running
- CLK  in  1  clock, rising edge
- RESET_N  in  1  asynchronous active-low reset
- CLEAR  in  1  synchronous clear; same effect as reset, one cycle
- ref_valid  in  1  reference core store this cycle (MemWrite / d_rw)
- ref_addr  in  ADDR_WIDTH  reference store address
- ref_data  in  DATA_WIDTH  reference store data
- dut_valid  in  1  DUT core store this cycle
- dut_addr  in  ADDR_WIDTH  DUT store address
- dut_data  in  DATA_WIDTH  DUT store data
- match_count  out  CNT_WIDTH  compared pairs equal
- mismatch_count  out  CNT_WIDTH  compared pairs differing
- mismatch  out  1  sticky: at least one mismatch seen
- first_ref_addr / first_ref_data  out  ADDR_WIDTH / DATA_WIDTH  reference entry of first mismatch
- first_dut_addr / first_dut_data  out  ADDR_WIDTH / DATA_WIDTH  DUT entry of first mismatch
- overflow  out  1  sticky: an entry was dropped on a full FIFO
- timeout  out  1  sticky: one trace led the other for TIMEOUT cycles
- halted  out  1  state is HALT

## Operation
- Reset or CLEAR: both FIFOs empty; all counters, sticky flags, capture registers and halted set to 0; state RUN.
- Push: a valid input writes {addr,data} into its FIFO at the rising edge. A push to a full FIFO is accepted only if that FIFO pops in the same cycle. Otherwise the entry is dropped and overflow is set.
- Compare: when both FIFOs are non-empty and state ≠ HALT, both heads pop in the same cycle. The pair matches iff addr and data are both equal.
- Match: match_count +1. Mismatch: mismatch_count +1 and mismatch set. If mismatch was previously 0, the four first_* registers load the pair; they are otherwise never overwritten.
- Counters saturate at 2^CNT_WIDTH−1 and do not wrap.
- FSM states:
  - RUN: both FIFOs empty or both non-empty. If exactly one is non-empty, go to WAIT with wait_cnt=1.
  - WAIT: wait_cnt +1 per cycle. Return to RUN on a pop or when both FIFOs are empty. On wait_cnt==TIMEOUT, set timeout; the state stays WAIT and the counter holds.
  - HALT: entered from RUN or WAIT on a mismatch when STOP_ON_MISMATCH=1. No pops. Pushes continue until the FIFOs are full, then overflow applies. Exit only via reset or CLEAR.
- Simultaneous push and pop on the same FIFO: occupancy is unchanged; the popped entry is the old head.
- Reset mid-operation: all FIFO contents are discarded immediately (asynchronous); no partial compare is counted.

## Timing
- FIFOs are registered. An entry pushed at edge k is visible at the head after k.
- Pop and compare happen at edge k+1 at the earliest. Counters, flags and first_* are visible after k+1, so minimum latency from store to count is 2 cycles.
- Throughput: one compare per cycle.
- All outputs are registered. No combinational path exists from inputs to outputs.
- halted asserts the cycle after the mismatching pop.
- timeout asserts the cycle after wait_cnt reaches TIMEOUT.

## Structure
- Package lockstep_pkg:
  - trace_entry_t packed struct {addr, data}, parametrised through package localparams with defaults.
  - chk_state_t enum {RUN, WAIT, HALT}.
- Sub-module trace_fifo (DEPTH, entry width): synchronous write/read, pointers with an extra wrap bit, full/empty flags, asynchronous reset. It is instantiated twice, once for the reference trace and once for the DUT trace.
- The top contains the compare logic, FSM, saturating counters and capture registers.

## Test plan
- Identical streams: both cores store (0x010,5),(0x014,8),(0x018,13), with DUT delayed 3 cycles. Result: match_count=3, mismatch=0, timeout=0.
- Data mismatch, STOP_ON_MISMATCH=1: ref (0x020,0xAA), dut (0x020,0xAB), then 2 further matching pairs. Result: mismatch_count=1, first_* = 0x020/0xAA and 0x020/0xAB, halted=1, match_count=0.
- Same stream with STOP_ON_MISMATCH=0. Result: mismatch_count=1, match_count=2, halted=0, first_* unchanged by later pairs.
- Overflow, DEPTH=8: 9 ref stores with no DUT stores. Result: overflow=1, timeout=1 after 64 cycles. Then 8 matching DUT stores give match_count=8.
- Counter saturation, CNT_WIDTH=4: 20 matching pairs. Result: match_count=15.
- Reset mid-stream: assert RESET_N=0 with 3 pending ref entries. Result: all outputs 0 immediately. Afterwards 1 matching pair gives match_count=1. Repeat the sequence with CLEAR and expect the same result.
